fpu_writeback_csr: RTL and testbench
====================================

// Module: fpu_writeback_csr
// PURPOSE
// - Downstream stage of the single-cycle FPU top: tracks each issued op through the FPU's fixed 2-cycle latency,
//   captures result/flags into a small writeback FIFO, drives a valid/ready writeback port to the FP/int register files.
// - Owns the architectural fflags/frm CSR state; fflags accrue on retirement, frm feeds the FPU frm input.
// PARAMETERS
// - DEPTH   4   writeback FIFO entries (power of 2, >=2)
// - LAT     2   FPU issue-to-result latency in cycles (input reg + output reg)
// - XLEN    32  result/data width
// PORTS
// - clk          in   1     clock
// - rst_l        in   1     asynchronous active-low reset
// - issue_valid  in   1     op presented to FPU operand/opcode inputs this cycle
// - issue_ready  out  1     stage can accept an issue this cycle
// - issue_rd     in   5     destination register index
// - issue_to_int in   1     1: integer rd (cmp, fclass, fcvt.w, fmv.x.w); 0: float rd
// - fpu_res_f    in   XLEN  FPU float result (FPU_resultant)
// - fpu_res_i    in   XLEN  FPU integer result (FPU_Result_rd)
// - fpu_flags    in   5     FPU S_Flags {NV,DZ,OF,UF,NX}
// - fpu_exc      in   1     FPU Exception_flag
// - wb_valid     out  1     writeback entry available
// - wb_ready     in   1     register file accepts entry
// - wb_rd        out  5     entry destination index
// - wb_to_int    out  1     entry targets integer file
// - wb_data      out  XLEN  fpu_res_i if to_int else fpu_res_f
// - wb_exc       out  1     entry raised FPU exception
// - csr_we       in   1     CSR write strobe
// - csr_sel      in   2     01 fflags, 10 frm, 11 fcsr; 00 no-op
// - csr_wdata    in   8     write data (fcsr = {frm[2:0],fflags[4:0]})
// - csr_rdata    out  8     read data for csr_sel, zero-extended; 0 for sel 00
// - frm          out  3     current rounding mode to FPU
// BEHAVIOUR
// - Reset (async, rst_l=0): FIFO empty, tag pipe cleared, fflags=0, frm=0; wb_valid=0, wb_rd=0, wb_to_int=0,
//   wb_data=0, wb_exc=0, csr_rdata=0 (sel 00), issue_ready=1. In-flight ops are dropped, never written back.
// - Issue accepted when issue_valid & issue_ready; {rd,to_int} enter LAT-deep tag shift register with valid bit.
// - Tag reaching stage LAT samples fpu_res_f/fpu_res_i/fpu_flags/fpu_exc that same cycle and pushes one FIFO entry.
// - issue_ready = (fifo_count + inflight_count) < DEPTH; guarantees push never overflows; no result ever lost.
// - FIFO pops on wb_valid & wb_ready; push and pop same cycle: count unchanged; pointers wrap mod DEPTH.
// - Empty: wb_valid=0, wb_* hold last popped values. Full: issue_ready=0.
// - Pop retires entry: fflags <= fflags | entry.flags.
// - CSR write same cycle as retire: fflags <= csr_wdata-field | retiring flags (accrual never lost).
// - frm write: frm <= csr_wdata[2:0] next edge; ops issued same cycle use old frm. frm values 5,6 stored as-is.
// - csr_rdata combinational from current (pre-update) CSR state.
// CONFIGURATION
// - FPU_WB_BYPASS_EN defined: FIFO empty & wb_ready & result arriving -> entry driven on wb_* combinationally
//   same cycle, not pushed (0-cycle FIFO latency); flags retire that cycle.
// - Not defined: every result pushed; earliest wb_valid is the cycle after result arrival (issue+LAT+1).
// TESTING
// - Reset, issue fadd rd=3, flags=00001, wb_ready=1 -> wb_valid at issue+3 (issue+2 with BYPASS), wb_rd=3, fflags=01.
// - Issue feq rd=7 to_int=1, fpu_res_i=1 -> wb_to_int=1, wb_data=0x00000001, fflags unchanged.
// - wb_ready=0, issue every cycle -> exactly 4 accepted, issue_ready=0; release -> 4 writebacks in order.
// - Retire NV entry while csr_we fflags=0x00 same cycle -> fflags=0x10; fcsr read = {frm,0x10}.
// - Write frm=3 (csr_sel=10,wdata=0x03) -> frm=3 next cycle, csr_rdata(fcsr)[7:5]=3, fflags intact.
// - Assert rst_l=0 with 2 ops in flight and 2 queued -> wb_valid=0 immediately; no writebacks after release.

Source files
------------

// File: rtl/fpu_writeback_csr_if.sv
// Writeback port from the FPU writeback stage to the FP/integer register files.
// master = writeback stage, slave = register-file side.
interface fpu_writeback_csr_if #(
    parameter int XLEN = 32
);
    // An entry transfers on any rising edge where wb_valid and wb_ready are both high.
    // The master never withdraws wb_valid or changes the payload while wb_valid & ~wb_ready.
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic            wb_to_int;
    logic [XLEN-1:0] wb_data;
    logic            wb_exc;

    modport master (
        output wb_valid, wb_rd, wb_to_int, wb_data, wb_exc,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_rd, wb_to_int, wb_data, wb_exc,
        output wb_ready
    );
endinterface

// File: rtl/fpu_writeback_csr.sv
// FPU writeback stage: tracks ops through the fixed FPU latency, queues results, owns fflags/frm.
// Optional FPU_WB_BYPASS_EN: result goes straight to the writeback port when the queue is empty and ready.
module fpu_writeback_csr #(
    parameter int DEPTH = 4,
    parameter int LAT   = 2,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [4:0]            issue_rd,
    input  logic                  issue_to_int,
    input  logic [XLEN-1:0]       fpu_res_f,
    input  logic [XLEN-1:0]       fpu_res_i,
    input  logic [4:0]            fpu_flags,
    input  logic                  fpu_exc,
    fpu_writeback_csr_if.master   wb,
    input  logic                  csr_we,
    input  logic [1:0]            csr_sel,
    input  logic [7:0]            csr_wdata,
    output logic [7:0]            csr_rdata,
    output logic [2:0]            frm
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + LAT + 1) + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic            to_int;
        logic [XLEN-1:0] data;
        logic            exc;
        logic [4:0]      flags;
    } entry_t;

    logic [LAT-1:0] tag_v;
    logic [4:0]     tag_rd  [LAT];
    logic           tag_int [LAT];

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    entry_t         last_q;

    logic [4:0]     fflags_q;
    logic [2:0]     frm_q;

    logic           issue_fire, arrive, empty, bypass, push, pop, retire;
    logic [OW-1:0]  inflight, occ;
    entry_t         arr_entry, out_entry;
    logic [4:0]     ret_flags;

    // Occupancy counts ops still inside the FPU so a result always has a FIFO slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + OW'(tag_v[i]);
        end
        occ         = OW'(count) + inflight;
        issue_ready = occ < OW'(DEPTH);
        issue_fire  = issue_valid & issue_ready;
    end

    always_comb begin
        arrive           = tag_v[LAT-1];
        arr_entry.rd     = tag_rd[LAT-1];
        arr_entry.to_int = tag_int[LAT-1];
        arr_entry.data   = tag_int[LAT-1] ? fpu_res_i : fpu_res_f;
        arr_entry.exc    = fpu_exc;
        arr_entry.flags  = fpu_flags;
        empty            = (count == '0);
`ifdef FPU_WB_BYPASS_EN
        bypass           = empty & arrive & wb.wb_ready;
`else
        bypass           = 1'b0;
`endif
        push             = arrive & ~bypass;
        pop              = ~empty & wb.wb_ready;
        retire           = pop | bypass;
        if (!empty)      out_entry = mem[rd_ptr];
        else if (bypass) out_entry = arr_entry;
        else             out_entry = last_q;
        ret_flags        = retire ? out_entry.flags : 5'b0;
    end

    assign wb.wb_valid  = ~empty | bypass;
    assign wb.wb_rd     = out_entry.rd;
    assign wb.wb_to_int = out_entry.to_int;
    assign wb.wb_data   = out_entry.data;
    assign wb.wb_exc    = out_entry.exc;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tag_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_rd[i]  <= '0;
                tag_int[i] <= 1'b0;
            end
        end else begin
            tag_v[0]   <= issue_fire;
            tag_rd[0]  <= issue_rd;
            tag_int[0] <= issue_to_int;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_rd[i]  <= tag_rd[i-1];
                tag_int[i] <= tag_int[i-1];
            end
        end
    end

    // Storage needs no reset: an entry is only read once count says it was written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= arr_entry;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (retire) last_q <= out_entry;
        end
    end

    // A CSR write to fflags still ORs in the flags retiring that cycle.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            fflags_q <= '0;
            frm_q    <= '0;
        end else begin
            if (csr_we && csr_sel[0]) fflags_q <= csr_wdata[4:0] | ret_flags;
            else                      fflags_q <= fflags_q | ret_flags;
            if (csr_we && csr_sel == 2'b10)      frm_q <= csr_wdata[2:0];
            else if (csr_we && csr_sel == 2'b11) frm_q <= csr_wdata[7:5];
        end
    end

    always_comb begin
        case (csr_sel)
            2'b01:   csr_rdata = {3'b000, fflags_q};
            2'b10:   csr_rdata = {5'b00000, frm_q};
            2'b11:   csr_rdata = {frm_q, fflags_q};
            default: csr_rdata = 8'h00;
        endcase
    end

    assign frm = frm_q;
endmodule

// File: tb/tb_fpu_writeback_csr.sv
// Self-checking bench for fpu_writeback_csr: directed scenarios plus random traffic vs a queue model.
module tb_fpu_writeback_csr;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int XLEN  = 32;
    localparam int EW    = 5 + 1 + XLEN + 1 + 5;
`ifdef FPU_WB_BYPASS_EN
    localparam int WB_LAT = LAT;
    localparam bit BYP    = 1'b1;
`else
    localparam int WB_LAT = LAT + 1;
    localparam bit BYP    = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_l;
    logic issue_valid, issue_ready, issue_to_int, fpu_exc, csr_we;
    logic [4:0] issue_rd, fpu_flags;
    logic [XLEN-1:0] fpu_res_f, fpu_res_i;
    logic [1:0] csr_sel;
    logic [7:0] csr_wdata, csr_rdata;
    logic [2:0] frm;

    fpu_writeback_csr_if #(.XLEN(XLEN)) wb_if ();

    fpu_writeback_csr #(.DEPTH(DEPTH), .LAT(LAT), .XLEN(XLEN)) dut (
        .clk(clk), .rst_l(rst_l),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rd(issue_rd), .issue_to_int(issue_to_int),
        .fpu_res_f(fpu_res_f), .fpu_res_i(fpu_res_i),
        .fpu_flags(fpu_flags), .fpu_exc(fpu_exc),
        .wb(wb_if.master),
        .csr_we(csr_we), .csr_sel(csr_sel), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .frm(frm)
    );

    // clock/reset block
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic            to_int;
        logic [XLEN-1:0] rf;
        logic [XLEN-1:0] ri;
        logic [4:0]      flags;
        logic            exc;
        int              issue_cyc;
    } op_t;

    // scoreboard: ops inside the FPU, and results waiting for writeback in order
    op_t            pend_q[$];
    logic [EW-1:0]  exp_q[$];
    logic [EW-1:0]  last_exp;
    logic [4:0]     m_fflags;
    logic [2:0]     m_frm;
    op_t            nxt;
    int cyc, checks, errors, first_wb_cyc, accepted, dut_wb_count, c0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic set_issue(input logic [4:0] rd, input logic to_int, input logic [XLEN-1:0] rf,
                             input logic [XLEN-1:0] ri, input logic [4:0] flags, input logic exc);
        issue_valid  = 1'b1;
        issue_rd     = rd;
        issue_to_int = to_int;
        nxt.rd = rd; nxt.to_int = to_int; nxt.rf = rf; nxt.ri = ri;
        nxt.flags = flags; nxt.exc = exc; nxt.issue_cyc = 0;
    endtask

    task automatic set_rand_issue();
        set_issue(5'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom));
        issue_valid = 1'($urandom_range(0, 1));
    endtask

    // One clock: drive the FPU model, check DUT at negedge, advance the model.
    task automatic cycle();
        op_t a;
        bit arr, exp_ready, exp_valid, byp, ret, acc;
        logic [EW-1:0] ae, head;
        logic [4:0] rflags;
        logic [7:0] er;
        arr = (pend_q.size() > 0) && (pend_q[0].issue_cyc + LAT == cyc);
        if (arr) begin
            a = pend_q[0];
            fpu_res_f = a.rf; fpu_res_i = a.ri; fpu_flags = a.flags; fpu_exc = a.exc;
        end else begin
            a = nxt;
            fpu_res_f = $urandom; fpu_res_i = $urandom; fpu_flags = 5'($urandom); fpu_exc = 1'($urandom);
        end
        @(negedge clk);
        exp_ready = (pend_q.size() + exp_q.size()) < DEPTH;
        chk("issue_ready", 64'(issue_ready), 64'(exp_ready));
        acc = issue_valid && exp_ready;
        ae = arr ? {a.rd, a.to_int, (a.to_int ? a.ri : a.rf), a.exc, a.flags} : '0;
        byp = BYP && arr && (exp_q.size() == 0) && wb_if.wb_ready;
        exp_valid = (exp_q.size() > 0) || byp;
        chk("wb_valid", 64'(wb_if.wb_valid), 64'(exp_valid));
        if (exp_q.size() > 0) head = exp_q[0];
        else if (byp)         head = ae;
        else                  head = last_exp;
        chk("wb_rd", 64'(wb_if.wb_rd), 64'(head[43:39]));
        chk("wb_to_int", 64'(wb_if.wb_to_int), 64'(head[38]));
        chk("wb_data", 64'(wb_if.wb_data), 64'(head[37:6]));
        chk("wb_exc", 64'(wb_if.wb_exc), 64'(head[5]));
        if (wb_if.wb_valid && wb_if.wb_ready) dut_wb_count++;
        case (csr_sel)
            2'b01:   er = {3'b000, m_fflags};
            2'b10:   er = {5'b00000, m_frm};
            2'b11:   er = {m_frm, m_fflags};
            default: er = 8'h00;
        endcase
        chk("csr_rdata", 64'(csr_rdata), 64'(er));
        chk("frm", 64'(frm), 64'(m_frm));
        ret = exp_valid && wb_if.wb_ready;
        rflags = ret ? head[4:0] : 5'b0;
        if (ret) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            last_exp = head;
            if (first_wb_cyc < 0) first_wb_cyc = cyc;
        end
        if (arr) begin
            void'(pend_q.pop_front());
            if (!byp) exp_q.push_back(ae);
        end
        if (acc) begin
            nxt.issue_cyc = cyc;
            pend_q.push_back(nxt);
            accepted++;
        end
        if (csr_we && csr_sel[0]) m_fflags = csr_wdata[4:0] | rflags;
        else                      m_fflags = m_fflags | rflags;
        if (csr_we && csr_sel == 2'b10)      m_frm = csr_wdata[2:0];
        else if (csr_we && csr_sel == 2'b11) m_frm = csr_wdata[7:5];
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; accepted = 0; dut_wb_count = 0; first_wb_cyc = -1;
        last_exp = '0; m_fflags = '0; m_frm = '0;
        rst_l = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_to_int = 1'b0;
        fpu_res_f = '0; fpu_res_i = '0; fpu_flags = '0; fpu_exc = 1'b0;
        wb_if.wb_ready = 1'b0; csr_we = 1'b0; csr_sel = 2'b00; csr_wdata = '0;
        set_issue(5'd0, 1'b0, '0, '0, '0, 1'b0);
        issue_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", 64'(wb_if.wb_valid), 64'd0);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        chk("rst_wb_data", 64'(wb_if.wb_data), 64'd0);
        chk("rst_csr_rdata", 64'(csr_rdata), 64'd0);
        chk("rst_frm", 64'(frm), 64'd0);
        rst_l = 1'b1;

        // fadd rd=3 raising NX
        wb_if.wb_ready = 1'b1;
        first_wb_cyc = -1;
        c0 = cyc;
        set_issue(5'd3, 1'b0, 32'h4040_0000, 32'h0, 5'b00001, 1'b0);
        cycle();
        issue_valid = 1'b0;
        idle(5);
        chk("fadd_latency", 64'(first_wb_cyc), 64'(c0 + WB_LAT));
        csr_sel = 2'b01;
        #1;
        chk("fadd_fflags", 64'(csr_rdata), 64'h01);

        // feq to integer file
        set_issue(5'd7, 1'b1, 32'hdead_beef, 32'h0000_0001, 5'b00000, 1'b0);
        cycle();
        issue_valid = 1'b0;
        idle(5);
        #1;
        chk("feq_fflags", 64'(csr_rdata), 64'h01);

        // back-pressure: only DEPTH ops may be outstanding
        wb_if.wb_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            set_issue(5'(i + 10), 1'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom));
            cycle();
        end
        chk("full_accepted", 64'(accepted), 64'd4);
        chk("full_issue_ready", 64'(issue_ready), 64'd0);
        issue_valid = 1'b0;
        wb_if.wb_ready = 1'b1;
        dut_wb_count = 0;
        idle(8);
        chk("full_drain_count", 64'(dut_wb_count), 64'd4);

        // NV retiring in the same cycle as an fflags write of zero
        wb_if.wb_ready = 1'b0;
        set_issue(5'd9, 1'b0, 32'h7fc0_0000, 32'h0, 5'b10000, 1'b1);
        cycle();
        issue_valid = 1'b0;
        idle(4);
        wb_if.wb_ready = 1'b1;
        csr_we = 1'b1; csr_sel = 2'b01; csr_wdata = 8'h00;
        cycle();
        csr_we = 1'b0; csr_sel = 2'b11;
        #1;
        chk("nv_fcsr", 64'(csr_rdata), 64'h10);

        // frm write
        csr_we = 1'b1; csr_sel = 2'b10; csr_wdata = 8'h03;
        cycle();
        csr_we = 1'b0; csr_sel = 2'b11;
        #1;
        chk("frm_out", 64'(frm), 64'd3);
        chk("frm_fcsr", 64'(csr_rdata), 64'h70);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            set_rand_issue();
            wb_if.wb_ready = ($urandom_range(0, 9) < 7);
            csr_we = ($urandom_range(0, 7) == 0);
            csr_sel = 2'($urandom);
            csr_wdata = 8'($urandom);
            cycle();
        end
        issue_valid = 1'b0; csr_we = 1'b0; wb_if.wb_ready = 1'b1;
        idle(10);

        // reset with two ops queued and two in flight
        wb_if.wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_issue(5'(i + 20), 1'b0, $urandom, $urandom, 5'($urandom), 1'b0);
            cycle();
        end
        issue_valid = 1'b0;
        wb_if.wb_ready = 1'b1;
        csr_sel = 2'b00;
        rst_l = 1'b0;
        #1;
        chk("arst_wb_valid", 64'(wb_if.wb_valid), 64'd0);
        chk("arst_issue_ready", 64'(issue_ready), 64'd1);
        chk("arst_wb_rd", 64'(wb_if.wb_rd), 64'd0);
        chk("arst_frm", 64'(frm), 64'd0);
        pend_q.delete(); exp_q.delete();
        last_exp = '0; m_fflags = '0; m_frm = '0;
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        cyc++;
        dut_wb_count = 0;
        idle(10);
        chk("arst_no_wb", 64'(dut_wb_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
